// File: rtl/mdu_pipe.sv
// mdu_pipe: multi-cycle multiply/divide unit with HI/LO, flush and busy for the E stage.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 9-12).
module mdu_pipe #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [3:0]       MDU_op,
  input  logic [WIDTH-1:0] RS,
  input  logic [WIDTH-1:0] RT,
  output logic [WIDTH-1:0] MDU_OUT,
  output logic             MDU_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXL = MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  localparam int W2   = 2 * WIDTH;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    pend, res, prod_s, prod_u;
  logic             pend_wr, wr, is_mul, is_div, is_start, accept;
  logic [WIDTH-1:0] abs_a, abs_b, sdv, sq0, sr0, sq, sr, udv, uq, ur;
  assign prod_s = {{WIDTH{RS[WIDTH-1]}}, RS} * {{WIDTH{RT[WIDTH-1]}}, RT};
  assign prod_u = {{WIDTH{1'b0}}, RS} * {{WIDTH{1'b0}}, RT};
  // Signed divide on magnitudes; most-negative / -1 falls out as quotient = most-negative, remainder 0.
  assign abs_a = RS[WIDTH-1] ? -RS : RS;
  assign abs_b = RT[WIDTH-1] ? -RT : RT;
  assign sdv   = (abs_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
  assign sq0   = abs_a / sdv;
  assign sr0   = abs_a % sdv;
  assign sq    = (RS[WIDTH-1] ^ RT[WIDTH-1]) ? -sq0 : sq0;
  assign sr    = RS[WIDTH-1] ? -sr0 : sr0;
  assign udv   = (RT == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : RT;
  assign uq    = RS / udv;
  assign ur    = RS % udv;
`ifdef MDU_MADD_EN
  assign is_mul = (MDU_op == OP_MULT) | (MDU_op == OP_MULTU) | (MDU_op >= OP_MADD && MDU_op <= OP_MSUBU);
`else
  assign is_mul = (MDU_op == OP_MULT) | (MDU_op == OP_MULTU);
`endif
  assign is_div   = (MDU_op == OP_DIV) | (MDU_op == OP_DIVU);
  assign is_start = is_mul | is_div;
  assign accept   = is_start & ~req & (cnt == '0);
  assign MDU_busy = (cnt != '0) | (is_start & ~req);
  assign MDU_OUT  = (MDU_op == OP_MFHI) ? hi : (MDU_op == OP_MFLO) ? lo : '0;
  assign wr       = ~is_div | (RT != '0);
  always_comb begin
    res = prod_s;
    case (MDU_op)
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {sr, sq};
      OP_DIVU:  res = {ur, uq};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi, lo} + prod_s;
      OP_MADDU: res = {hi, lo} + prod_u;
      OP_MSUB:  res = {hi, lo} - prod_s;
      OP_MSUBU: res = {hi, lo} - prod_u;
`endif
      default:  res = prod_s;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && pend_wr) {hi, lo} <= pend;
    end else if (accept) begin
      cnt     <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      pend    <= res;
      pend_wr <= wr;
    end else if (!req && MDU_op == OP_MTHI) begin
      hi <= RS;
    end else if (!req && MDU_op == OP_MTLO) begin
      lo <= RS;
    end
  end
endmodule

// File: tb/tb_mdu_pipe.sv
// tb_mdu_pipe: randomized and directed checks of mdu_pipe against a cycle-stamped reference model.
module tb_mdu_pipe;
  localparam int ML = 5;
  localparam int DL = 10;
  logic        clk = 1'b0, reset = 1'b0, req = 1'b0;
  logic [3:0]  MDU_op = '0;
  logic [31:0] RS = '0, RT = '0;
  logic [31:0] MDU_OUT, hi, lo;
  logic        MDU_busy;
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, done_at = -1;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] p_val = '0;
  logic        p_wr = 1'b0;
  always #5 clk = ~clk;
  mdu_pipe #(.WIDTH(32), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .req(req), .MDU_op(MDU_op), .RS(RS), .RT(RT),
    .MDU_OUT(MDU_OUT), .MDU_busy(MDU_busy), .hi(hi), .lo(lo)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  function automatic bit is_start(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 1 && op <= 4) || (op >= 9 && op <= 12);
`else
    return op >= 1 && op <= 4;
`endif
  endfunction
  // {write_enable, {HI,LO}} from the architectural definition of each op
  function automatic logic [64:0] model_res(input logic [3:0] op, input logic [31:0] a, b, h, l);
    longint      sp;
    logic [63:0] spv, up, acc;
    int          q, r;
    sp  = longint'($signed(a)) * longint'($signed(b));
    spv = sp;
    up  = {32'b0, a} * {32'b0, b};
    acc = {h, l};
    case (op)
      4'd1: return {1'b1, spv};
      4'd2: return {1'b1, up};
      4'd3: begin
        if (b == 0) return {1'b0, 64'b0};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b1, 32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {1'b1, r, q};
      end
      4'd4: return (b == 0) ? {1'b0, 64'b0} : {1'b1, a % b, a / b};
      4'd9:  return {1'b1, acc + spv};
      4'd10: return {1'b1, acc + up};
      4'd11: return {1'b1, acc - spv};
      4'd12: return {1'b1, acc - up};
      default: return '0;
    endcase
  endfunction
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq, input logic rn);
    bit idle, st;
    @(negedge clk);
    MDU_op = op; RS = a; RT = b; req = rq; reset = rn;
    #1;
    idle = cyc > done_at;
    st   = is_start(op);
    if (rn) begin
      check("busy", {63'b0, MDU_busy}, {63'b0, !idle || (st && !rq)});
      check("mdu_out", {32'b0, MDU_OUT}, {32'b0, op == 5 ? m_hi : op == 6 ? m_lo : 32'h0});
    end
    @(posedge clk);
    if (!rn) begin
      m_hi = '0; m_lo = '0; done_at = -1;
    end else if (cyc == done_at) begin
      if (p_wr) {m_hi, m_lo} = p_val;
    end else if (idle && st && !rq) begin
      {p_wr, p_val} = model_res(op, a, b, m_hi, m_lo);
      done_at = cyc + ((op == 3 || op == 4) ? DL : ML);
    end else if (idle && !rq && op == 7) begin
      m_hi = a;
    end else if (idle && !rq && op == 8) begin
      m_lo = a;
    end
    cyc++;
    #1;
    check("hi", {32'b0, hi}, {32'b0, m_hi});
    check("lo", {32'b0, lo}, {32'b0, m_lo});
  endtask
  task automatic idle_n(input int n);
    repeat (n) step(4'd0, '0, '0, 1'b0, 1'b1);
  endtask
  function automatic logic [31:0] rv();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [3:0]  op;
    logic [31:0] sh, sl;
    step(4'd0, '0, '0, 1'b0, 1'b0);
    step(4'd0, '0, '0, 1'b0, 1'b0);
    step(4'd5, '0, '0, 1'b0, 1'b1);
    check("reset_mfhi", {32'b0, MDU_OUT}, 64'h0);
    step(4'd6, '0, '0, 1'b0, 1'b1);
    check("reset_mflo", {32'b0, MDU_OUT}, 64'h0);
    step(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
    idle_n(ML);
    check("mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    step(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
    idle_n(ML);
    check("multu", {hi, lo}, 64'h00000001_FFFFFFFE);
    step(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
    idle_n(DL);
    check("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    step(4'd4, 32'd7, 32'd0, 1'b0, 1'b1);
    idle_n(DL);
    check("divu_zero", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    step(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    idle_n(DL);
    check("div_ovf", {hi, lo}, 64'h00000000_80000000);
    step(4'd1, 32'd3, 32'd4, 1'b1, 1'b1);
    check("req_mult", {hi, lo}, 64'h00000000_80000000);
    step(4'd1, 32'd3, 32'd4, 1'b0, 1'b1);
    step(4'd0, '0, '0, 1'b0, 1'b1);
    step(4'd0, '0, '0, 1'b1, 1'b1);
    idle_n(ML - 2);
    check("req_inflight", {hi, lo}, 64'd12);
    step(4'd1, 32'hFFFF0000, 32'h00010000, 1'b0, 1'b1);
    step(4'd7, 32'h1234, '0, 1'b0, 1'b1);
    idle_n(ML - 1);
    step(4'd8, 32'hABCD, '0, 1'b0, 1'b1);
    step(4'd6, '0, '0, 1'b0, 1'b1);
    check("mtlo_mflo", {32'b0, MDU_OUT}, 64'hABCD);
    step(4'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    idle_n(3);
    step(4'd0, '0, '0, 1'b0, 1'b0);
    step(4'd5, '0, '0, 1'b0, 1'b1);
    check("reset_mid_div", {hi, lo}, 64'h0);
`ifdef MDU_MADD_EN
    step(4'd8, 32'hFFFFFFFF, '0, 1'b0, 1'b1);
    step(4'd10, 32'd1, 32'd1, 1'b0, 1'b1);
    idle_n(ML);
    check("maddu", {hi, lo}, 64'h00000001_00000000);
    step(4'd11, 32'd1, 32'd1, 1'b0, 1'b1);
    idle_n(ML);
    check("msub", {hi, lo}, 64'h00000000_FFFFFFFF);
`else
    step(4'd8, 32'h55, '0, 1'b0, 1'b1);
    step(4'd9, 32'd1, 32'd1, 1'b0, 1'b1);
    check("op9_busy", {63'b0, MDU_busy}, 64'h0);
    idle_n(ML);
    check("op9_nochange", {hi, lo}, 64'h00000000_00000055);
`endif
    for (int i = 0; i < 1500; i++) begin
      op = 4'($urandom_range(0, 15));
      if (cyc <= done_at && is_start(op)) op = 4'd0;
      sh = rv();
      sl = rv();
      step(op, sh, sl, $urandom_range(0, 7) == 0, $urandom_range(0, 199) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
